// File: rtl/cpu_bus_tracer.sv
// cpu_bus_tracer
// Watches the 68000 bus next to the address decoder. Once per bus cycle, on the
// falling edge of the address strobe, it does two things:
//   - logs the access into a timestamped trace FIFO when the address is inside
//     the watch window;
//   - requests a halt when the address is inside the trap window.
// A debug or OSD consumer drains the FIFO through a valid/ready handshake.
//
// Parameters
//   DEPTH     trace FIFO entries (power of two, >= 2)
//   TS_WIDTH  free-running timestamp width in clk32 ticks (wraps)
//
// Ports
//   clk32          system clock, rising-edge
//   reset          synchronous, active-high
//   cpuAddr        CPU byte address
//   _cpuAS         address strobe, active low
//   _cpuRW         1 = read, 0 = write
//   watchLo/Hi     trace window [Lo, Hi)
//   trapLo/Hi      trap window  [Lo, Hi)
//   traceValid     FIFO head holds an entry
//   traceReady     consumer takes the head this cycle
//   traceData      {timestamp, rw, addr} of the FIFO head; zero when empty
//   overflowCount  saturating count of entries dropped on a full FIFO
//   haltReq        latched trap hit
//   haltClear      clears haltReq
module cpu_bus_tracer #(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned TS_WIDTH = 16
) (
    input  logic                  clk32,
    input  logic                  reset,
    input  logic [23:0]           cpuAddr,
    input  logic                  _cpuAS,
    input  logic                  _cpuRW,
    input  logic [23:0]           watchLo,
    input  logic [23:0]           watchHi,
    input  logic [23:0]           trapLo,
    input  logic [23:0]           trapHi,
    output logic                  traceValid,
    input  logic                  traceReady,
    output logic [TS_WIDTH+24:0]  traceData,
    output logic [7:0]            overflowCount,
    output logic                  haltReq,
    input  logic                  haltClear
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam int unsigned DW = TS_WIDTH + 25;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    typedef enum logic {
        IDLE,
        HALTED
    } haltState_e;

    logic                asPrev_q,    asPrev_d;
    logic [TS_WIDTH-1:0] timestamp_q, timestamp_d;
    logic [AW-1:0]       wrPtr_q,     wrPtr_d;
    logic [AW-1:0]       rdPtr_q,     rdPtr_d;
    logic [CW-1:0]       count_q,     count_d;
    logic [7:0]          overflow_q,  overflow_d;
    haltState_e          haltState_q, haltState_d;

    logic [DW-1:0]       mem_q [DEPTH];

    logic          busStart;
    logic          watchHit;
    logic          trapHit;
    logic          fifoFull;
    logic          popEn;
    logic          pushEn;
    logic          dropEn;
    logic [DW-1:0] newEntry;

    // Bus-cycle detection and FIFO control.
    // asPrev_q resets to 0, so a strobe that is already low when reset is
    // released produces no start; the next genuine falling edge does.
    // A full FIFO still accepts a push when the head pops in the same cycle,
    // so an entry is dropped only when the FIFO is full and nothing drains.
    always_comb begin
        busStart = asPrev_q & ~_cpuAS;
        watchHit = busStart && (cpuAddr >= watchLo) && (cpuAddr < watchHi);
        trapHit  = busStart && (cpuAddr >= trapLo)  && (cpuAddr < trapHi);
        fifoFull = (count_q == FULL_COUNT);
        popEn    = traceValid && traceReady;
        pushEn   = watchHit && (!fifoFull || popEn);
        dropEn   = watchHit && fifoFull && !popEn;
        newEntry = {timestamp_q, _cpuRW, cpuAddr};

        asPrev_d    = _cpuAS;
        timestamp_d = timestamp_q + TS_WIDTH'(1);
        wrPtr_d     = pushEn ? wrPtr_q + AW'(1) : wrPtr_q;
        rdPtr_d     = popEn  ? rdPtr_q + AW'(1) : rdPtr_q;

        count_d = count_q;
        case ({pushEn, popEn})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        overflow_d = overflow_q;
        if (dropEn && (overflow_q != 8'hFF)) begin
            overflow_d = overflow_q + 8'd1;
        end
    end

    // Control state. Reset discards the FIFO by clearing the pointers and the
    // occupancy; the storage itself does not need to be cleared.
    always_ff @(posedge clk32) begin
        if (reset) begin
            asPrev_q    <= 1'b0;
            timestamp_q <= '0;
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            count_q     <= '0;
            overflow_q  <= '0;
        end else begin
            asPrev_q    <= asPrev_d;
            timestamp_q <= timestamp_d;
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
        end
    end

    // Trace storage. It needs no reset because occupancy decides what is valid.
    always_ff @(posedge clk32) begin
        if (pushEn && !reset) begin
            mem_q[wrPtr_q] <= newEntry;
        end
    end

    // Head presentation. Data is forced to zero while the FIFO is empty.
    assign traceValid    = (count_q != '0);
    assign traceData     = traceValid ? mem_q[rdPtr_q] : '0;
    assign overflowCount = overflow_q;

    // Halt FSM: state register.
    always_ff @(posedge clk32) begin
        if (reset) begin
            haltState_q <= IDLE;
        end else begin
            haltState_q <= haltState_d;
        end
    end

    // Halt FSM: next state. A trap hit beats a clear in the same cycle.
    always_comb begin
        haltState_d = haltState_q;
        case (haltState_q)
            IDLE:    if (trapHit)                 haltState_d = HALTED;
            HALTED:  if (haltClear && !trapHit)   haltState_d = IDLE;
            default:                              haltState_d = IDLE;
        endcase
    end

    // Halt FSM: output.
    always_comb begin
        haltReq = (haltState_q == HALTED);
    end

endmodule

// File: tb/tb_cpu_bus_tracer.sv
// tb_cpu_bus_tracer
// Directed bench for cpu_bus_tracer. Bus cycles are driven just after a rising
// edge. Each expected trace entry goes into a scoreboard queue when its bus
// cycle is issued. A monitor pops that queue on each falling edge where the
// DUT completes a valid/ready handshake.
module tb_cpu_bus_tracer;

    localparam int DEPTH    = 16;
    localparam int TS_WIDTH = 16;
    localparam int DW       = TS_WIDTH + 25;

    logic                clk32 = 1'b0;
    logic                reset;
    logic [23:0]         cpuAddr;
    logic                _cpuAS;
    logic                _cpuRW;
    logic [23:0]         watchLo, watchHi, trapLo, trapHi;
    logic                traceValid;
    logic                traceReady;
    logic [DW-1:0]       traceData;
    logic [7:0]          overflowCount;
    logic                haltReq;
    logic                haltClear;

    int                  checks = 0;
    int                  errors = 0;
    logic [DW-1:0]       expQ [$];
    logic [TS_WIDTH-1:0] expTs;

    cpu_bus_tracer #(.DEPTH(DEPTH), .TS_WIDTH(TS_WIDTH)) dut (
        .clk32         (clk32),
        .reset         (reset),
        .cpuAddr       (cpuAddr),
        ._cpuAS        (_cpuAS),
        ._cpuRW        (_cpuRW),
        .watchLo       (watchLo),
        .watchHi       (watchHi),
        .trapLo        (trapLo),
        .trapHi        (trapHi),
        .traceValid    (traceValid),
        .traceReady    (traceReady),
        .traceData     (traceData),
        .overflowCount (overflowCount),
        .haltReq       (haltReq),
        .haltClear     (haltClear)
    );

    always #5 clk32 = ~clk32;

    // Reference timestamp: the number of clocks since the last reset edge.
    always @(posedge clk32) begin
        if (reset) expTs <= '0;
        else       expTs <= expTs + 16'd1;
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s got %h expected %h", name, actual, expected);
        end
    endtask

    // One bus cycle: the strobe stays low for 'hold' clocks, then one idle clock.
    // The expected entry is queued, or counted as a drop, at issue time.
    // popOnce raises traceReady for the start cycle only.
    task automatic applyStimulus(input logic [23:0] addr, input logic rw,
                                 input int hold, input logic popOnce);
        cpuAddr = addr;
        _cpuRW  = rw;
        _cpuAS  = 1'b0;
        if (popOnce) traceReady = 1'b1;
        if (addr >= watchLo && addr < watchHi) begin
            if (expQ.size() < DEPTH || (traceReady && expQ.size() > 0))
                expQ.push_back({expTs, rw, addr});
        end
        @(posedge clk32); #1;
        if (popOnce) traceReady = 1'b0;
        repeat (hold - 1) begin @(posedge clk32); #1; end
        _cpuAS = 1'b1;
        @(posedge clk32); #1;
    endtask

    // Drain the FIFO through the monitor, with a bounded wait, and then confirm
    // that the DUT holds nothing more than was expected.
    task automatic waitDrain(input string name);
        int budget = 0;
        traceReady = 1'b1;
        while (expQ.size() != 0 && budget < 64) begin
            @(posedge clk32); #1;
            budget++;
        end
        checkOutput({name, "Drained"}, 64'(expQ.size()), 64'd0);
        traceReady = 1'b0;
        @(negedge clk32);
        checkOutput({name, "EmptyAfter"}, 64'(traceValid), 64'd0);
        @(posedge clk32); #1;
    endtask

    // Scoreboard monitor.
    initial begin
        logic [DW-1:0] exp;
        forever begin
            @(negedge clk32);
            if (traceValid && traceReady) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpectedEntry got %h expected none", traceData);
                end else begin
                    exp = expQ.pop_front();
                    checkOutput("scoreboard", 64'(traceData), 64'(exp));
                end
            end
        end
    end

    // Watchdog.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1; _cpuAS = 1'b1; _cpuRW = 1'b1; cpuAddr = '0;
        traceReady = 1'b0; haltClear = 1'b0;
        watchLo = 24'h400000; watchHi = 24'h402000;
        trapLo  = 24'h000000; trapHi  = 24'h000000;

        repeat (3) @(posedge clk32);
        @(negedge clk32);
        checkOutput("resetValid",    64'(traceValid),    64'd0);
        checkOutput("resetData",     64'(traceData),     64'd0);
        checkOutput("resetOverflow", 64'(overflowCount), 64'd0);
        checkOutput("resetHalt",     64'(haltReq),       64'd0);
        @(posedge clk32); #1;
        reset = 1'b0;
        repeat (2) begin @(posedge clk32); #1; end

        $display("[TB] single read: entry appears one cycle after strobe fall");
        fork
            applyStimulus(24'h4001B8, 1'b1, 1, 1'b0);
            begin
                @(negedge clk32);
                checkOutput("validSameCycle", 64'(traceValid), 64'd0);
                @(negedge clk32);
                checkOutput("validNextCycle", 64'(traceValid), 64'd1);
                checkOutput("firstEntry", 64'(traceData), 64'({16'd2, 1'b1, 24'h4001B8}));
            end
        join
        waitDrain("t1");

        $display("[TB] long strobe and window boundaries");
        applyStimulus(24'h400010, 1'b0, 10, 1'b0);
        applyStimulus(24'h3FFFFF, 1'b1, 1, 1'b0);
        applyStimulus(24'h402000, 1'b1, 1, 1'b0);
        applyStimulus(24'h400000, 1'b1, 1, 1'b0);
        applyStimulus(24'h401FFF, 1'b0, 1, 1'b0);
        waitDrain("t2");

        $display("[TB] overflow and simultaneous push/pop on full");
        for (int i = 0; i < 17; i++)
            applyStimulus(24'h400100 + 24'(i * 4), 1'(i), 1, 1'b0);
        checkOutput("overflowAfter17", 64'(overflowCount), 64'd1);
        applyStimulus(24'h400500, 1'b1, 1, 1'b1);
        checkOutput("overflowPushPop", 64'(overflowCount), 64'd1);
        applyStimulus(24'h400504, 1'b0, 1, 1'b0);
        checkOutput("overflowStillFull", 64'(overflowCount), 64'd2);
        for (int i = 0; i < 300; i++)
            applyStimulus(24'h400600, 1'b1, 1, 1'b0);
        checkOutput("overflowSaturate", 64'(overflowCount), 64'd255);
        waitDrain("t3");

        $display("[TB] trap window halt");
        trapLo = 24'h402000; trapHi = 24'h800000;
        fork
            applyStimulus(24'h500000, 1'b1, 1, 1'b0);
            begin
                @(negedge clk32);
                checkOutput("haltSameCycle", 64'(haltReq), 64'd0);
                @(negedge clk32);
                checkOutput("haltNextCycle", 64'(haltReq), 64'd1);
            end
        join
        repeat (3) begin @(posedge clk32); #1; end
        checkOutput("haltLatched", 64'(haltReq), 64'd1);
        haltClear = 1'b1;
        fork
            applyStimulus(24'h600000, 1'b0, 1, 1'b0);
            begin
                @(posedge clk32); #1;
                haltClear = 1'b0;
                @(negedge clk32);
                checkOutput("haltTrapBeatsClear", 64'(haltReq), 64'd1);
            end
        join
        haltClear = 1'b1;
        @(posedge clk32); #1;
        haltClear = 1'b0;
        @(negedge clk32);
        checkOutput("haltCleared", 64'(haltReq), 64'd0);
        @(posedge clk32); #1;

        $display("[TB] reset mid-operation");
        for (int i = 0; i < 8; i++)
            applyStimulus(24'h400200 + 24'(i * 4), 1'b0, 1, 1'b0);
        applyStimulus(24'h500000, 1'b1, 1, 1'b0);
        checkOutput("haltBeforeReset", 64'(haltReq), 64'd1);
        checkOutput("validBeforeReset", 64'(traceValid), 64'd1);
        cpuAddr = 24'h400300;
        _cpuAS  = 1'b0;
        reset   = 1'b1;
        expQ.delete();
        repeat (2) begin @(posedge clk32); #1; end
        @(negedge clk32);
        checkOutput("midResetValid",    64'(traceValid),    64'd0);
        checkOutput("midResetData",     64'(traceData),     64'd0);
        checkOutput("midResetOverflow", 64'(overflowCount), 64'd0);
        checkOutput("midResetHalt",     64'(haltReq),       64'd0);
        @(posedge clk32); #1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk32);
            checkOutput("noEntryHeldStrobe", 64'(traceValid), 64'd0);
            @(posedge clk32); #1;
        end
        _cpuAS = 1'b1;
        @(posedge clk32); #1;
        fork
            applyStimulus(24'h400304, 1'b1, 1, 1'b0);
            begin
                @(negedge clk32);
                @(negedge clk32);
                checkOutput("postResetEntry", 64'(traceData), 64'({16'd4, 1'b1, 24'h400304}));
            end
        join
        waitDrain("t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
